// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: default geometry,
// the default-geometry register address type and the packed-port slicing helper.
package regfile_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 32;
   localparam int unsigned DEFAULT_NUM_REGS   = 32;
   localparam int unsigned DEFAULT_ADDR_W     = $clog2(DEFAULT_NUM_REGS);

   typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;

   // LSB position of field 'port' in a vector packing fields of 'width' bits
   function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
      return port * width;
   endfunction

endpackage

// File: rtl/regfile_if.sv
// Pipeline-to-register-file bus: writeback, issue and packed read ports.
// master = pipeline side, slave = register file side.
interface regfile_if #(
   parameter int unsigned DATA_WIDTH     = regfile_pkg::DEFAULT_DATA_WIDTH,
   parameter int unsigned NUM_REGS       = regfile_pkg::DEFAULT_NUM_REGS,
   parameter int unsigned NUM_READ_PORTS = 2
);
   localparam int unsigned ADDR_W = $clog2(NUM_REGS);

   logic                                 ctrl_writeEnable;
   logic [ADDR_W-1:0]                    ctrl_writeReg;
   logic [DATA_WIDTH-1:0]                data_writeReg;
   logic                                 ctrl_issueEnable;
   logic [ADDR_W-1:0]                    ctrl_issueReg;
   logic [NUM_READ_PORTS*ADDR_W-1:0]     ctrl_readReg;
   logic [NUM_READ_PORTS*DATA_WIDTH-1:0] data_readReg;
   logic [NUM_READ_PORTS-1:0]            readValid;
   logic [ADDR_W:0]                      pendingCount;

   modport master (
      output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
      output ctrl_issueEnable, ctrl_issueReg, ctrl_readReg,
      input  data_readReg, readValid, pendingCount
   );

   modport slave (
      input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
      input  ctrl_issueEnable, ctrl_issueReg, ctrl_readReg,
      output data_readReg, readValid, pendingCount
   );

endinterface

// File: rtl/regfile_cell.sv
// One architectural register plus its pending (awaiting writeback) bit.
// Issue wins over write for the pending bit; the data is still written.
module regfile_cell
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  ctrl_reset_n,
   input  logic                  write_en,
   input  logic                  issue_en,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  pending_o
);

   logic [DATA_WIDTH-1:0] data_d, data_q;
   logic                  pending_d, pending_q;

   // next-state: write stores data and clears pending, issue sets pending last
   always_comb begin
      data_d    = data_q;
      pending_d = pending_q;
      if (write_en) begin
         data_d    = write_data;
         pending_d = 1'b0;
      end
      if (issue_en) begin
         pending_d = 1'b1;
      end
   end

   // state registers, cleared asynchronously
   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         data_q    <= '0;
         pending_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         pending_q <= pending_d;
      end
   end

   assign data_o    = data_q;
   assign pending_o = pending_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised multi-read-port register file with per-register pending
// scoreboard and registered pending count.
// Optional macro REGFILE_BYPASS_EN: same-cycle write data forwarded to reads.
module regfile_param
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int unsigned NUM_REGS       = DEFAULT_NUM_REGS,
   parameter int unsigned NUM_READ_PORTS = 2,
   parameter int unsigned ZERO_REG       = 1,
   localparam int unsigned ADDR_W        = $clog2(NUM_REGS)
) (
   input  logic                                 clock,
   input  logic                                 ctrl_reset_n,
   input  logic                                 ctrl_writeEnable,
   input  logic [ADDR_W-1:0]                    ctrl_writeReg,
   input  logic [DATA_WIDTH-1:0]                data_writeReg,
   input  logic                                 ctrl_issueEnable,
   input  logic [ADDR_W-1:0]                    ctrl_issueReg,
   input  logic [NUM_READ_PORTS*ADDR_W-1:0]     ctrl_readReg,
   output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] data_readReg,
   output logic [NUM_READ_PORTS-1:0]            readValid,
   output logic [ADDR_W:0]                      pendingCount
);

   localparam logic [ADDR_W:0] COUNT_ONE = (ADDR_W+1)'(1);

   logic [DATA_WIDTH-1:0] reg_data  [NUM_REGS];
   logic [NUM_REGS-1:0]   reg_pend;
   logic [ADDR_W-1:0]     read_addr [NUM_READ_PORTS];
   logic                  write_eff, issue_eff;
   logic [ADDR_W:0]       pending_count_d, pending_count_q;

   // qualify write/issue: register 0 is inert when hardwired to zero
   always_comb begin
      write_eff = ctrl_writeEnable;
      issue_eff = ctrl_issueEnable;
      if (ZERO_REG != 0) begin
         if (ctrl_writeReg == '0) write_eff = 1'b0;
         if (ctrl_issueReg == '0) issue_eff = 1'b0;
      end
   end

   // storage: constant zero for the hardwired register, a cell elsewhere
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      if (i < ZERO_REG) begin : g_zero
         assign reg_data[i] = '0;
         assign reg_pend[i] = 1'b0;
      end else begin : g_cell
         regfile_cell #(
            .DATA_WIDTH (DATA_WIDTH)
         ) u_cell (
            .clock        (clock),
            .ctrl_reset_n (ctrl_reset_n),
            .write_en     (write_eff && (ctrl_writeReg == ADDR_W'(i))),
            .issue_en     (issue_eff && (ctrl_issueReg == ADDR_W'(i))),
            .write_data   (data_writeReg),
            .data_o       (reg_data[i]),
            .pending_o    (reg_pend[i])
         );
      end
   end

   // incremental popcount: +1 for a fresh issue, -1 for a write retiring a
   // pending register unless the same edge re-issues it
   always_comb begin
      pending_count_d = pending_count_q;
      if (issue_eff && !reg_pend[ctrl_issueReg]) begin
         pending_count_d = pending_count_d + COUNT_ONE;
      end
      if (write_eff && reg_pend[ctrl_writeReg] &&
          !(issue_eff && (ctrl_issueReg == ctrl_writeReg))) begin
         pending_count_d = pending_count_d - COUNT_ONE;
      end
   end

   // pending count register
   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         pending_count_q <= '0;
      end else begin
         pending_count_q <= pending_count_d;
      end
   end

   assign pendingCount = pending_count_q;

   for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_raddr
      assign read_addr[p] = ctrl_readReg[port_lsb(p, ADDR_W) +: ADDR_W];
   end

   // indexed read muxes, optionally overridden by the in-flight write
   always_comb begin
      data_readReg = '0;
      readValid    = '1;
      for (int unsigned p = 0; p < NUM_READ_PORTS; p++) begin
         data_readReg[port_lsb(p, DATA_WIDTH) +: DATA_WIDTH] = reg_data[read_addr[p]];
         readValid[p] = ~reg_pend[read_addr[p]];
`ifdef REGFILE_BYPASS_EN
         if (write_eff && (ctrl_writeReg == read_addr[p])) begin
            data_readReg[port_lsb(p, DATA_WIDTH) +: DATA_WIDTH] = data_writeReg;
            readValid[p] = !(issue_eff && (ctrl_issueReg == ctrl_writeReg));
         end
`endif
      end
   end

endmodule

// File: tb/tb_regfile_param.sv
// Directed + randomized bench for regfile_param: a default 32x32/2-port
// instance and an 8x16/3-port instance, both checked against array models.
`timescale 1ns/1ps
module tb_regfile_param;
   import regfile_pkg::*;

   localparam int unsigned DW  = 32, NR  = 32, NP  = 2, AW  = 5;
   localparam int unsigned DW8 = 16, NR8 = 8,  NP8 = 3, AW8 = 3;

   logic clock = 1'b0;
   logic ctrl_reset_n;
   always #5 clock = ~clock;

   regfile_if #(.DATA_WIDTH(DW),  .NUM_REGS(NR),  .NUM_READ_PORTS(NP))  bus  ();
   regfile_if #(.DATA_WIDTH(DW8), .NUM_REGS(NR8), .NUM_READ_PORTS(NP8)) bus8 ();

   regfile_param #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_READ_PORTS(NP), .ZERO_REG(1)) dut (
      .clock(clock), .ctrl_reset_n(ctrl_reset_n),
      .ctrl_writeEnable(bus.ctrl_writeEnable), .ctrl_writeReg(bus.ctrl_writeReg),
      .data_writeReg(bus.data_writeReg), .ctrl_issueEnable(bus.ctrl_issueEnable),
      .ctrl_issueReg(bus.ctrl_issueReg), .ctrl_readReg(bus.ctrl_readReg),
      .data_readReg(bus.data_readReg), .readValid(bus.readValid),
      .pendingCount(bus.pendingCount));

   regfile_param #(.DATA_WIDTH(DW8), .NUM_REGS(NR8), .NUM_READ_PORTS(NP8), .ZERO_REG(1)) dut8 (
      .clock(clock), .ctrl_reset_n(ctrl_reset_n),
      .ctrl_writeEnable(bus8.ctrl_writeEnable), .ctrl_writeReg(bus8.ctrl_writeReg),
      .data_writeReg(bus8.data_writeReg), .ctrl_issueEnable(bus8.ctrl_issueEnable),
      .ctrl_issueReg(bus8.ctrl_issueReg), .ctrl_readReg(bus8.ctrl_readReg),
      .data_readReg(bus8.data_readReg), .readValid(bus8.readValid),
      .pendingCount(bus8.pendingCount));

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   logic [DW-1:0]  m_reg  [NR];
   bit             m_pend [NR];
   logic [DW8-1:0] m8_reg  [NR8];
   bit             m8_pend [NR8];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int unsigned r = 0; r < NR; r++) begin m_reg[r] = '0; m_pend[r] = 1'b0; end
      for (int unsigned r = 0; r < NR8; r++) begin m8_reg[r] = '0; m8_pend[r] = 1'b0; end
   endtask

   // architectural effect of one rising edge (register 0 hardwired to zero)
   task automatic model_edge();
      if (ctrl_reset_n) begin
         if (bus.ctrl_writeEnable && bus.ctrl_writeReg != 0) begin
            m_reg[bus.ctrl_writeReg]  = bus.data_writeReg;
            m_pend[bus.ctrl_writeReg] = 1'b0;
         end
         if (bus.ctrl_issueEnable && bus.ctrl_issueReg != 0) m_pend[bus.ctrl_issueReg] = 1'b1;
         if (bus8.ctrl_writeEnable && bus8.ctrl_writeReg != 0) begin
            m8_reg[bus8.ctrl_writeReg]  = bus8.data_writeReg;
            m8_pend[bus8.ctrl_writeReg] = 1'b0;
         end
         if (bus8.ctrl_issueEnable && bus8.ctrl_issueReg != 0) m8_pend[bus8.ctrl_issueReg] = 1'b1;
      end
   endtask

   task automatic check_main(input string tag);
      int unsigned c = 0;
      for (int unsigned p = 0; p < NP; p++) begin
         reg_addr_t     a;
         logic [DW-1:0] ed;
         logic          ev;
         a  = bus.ctrl_readReg[p*AW +: AW];
         ed = m_reg[a];
         ev = !m_pend[a];
         if (a == 0) begin
            ed = '0;
            ev = 1'b1;
         end
`ifdef REGFILE_BYPASS_EN
         else if (bus.ctrl_writeEnable && bus.ctrl_writeReg == a) begin
            ed = bus.data_writeReg;
            ev = !(bus.ctrl_issueEnable && bus.ctrl_issueReg == a);
         end
`endif
         check($sformatf("%s.data%0d", tag, p), 64'(bus.data_readReg[p*DW +: DW]), 64'(ed));
         check($sformatf("%s.valid%0d", tag, p), 64'(bus.readValid[p]), 64'(ev));
      end
      for (int unsigned r = 0; r < NR; r++) if (m_pend[r]) c++;
      check($sformatf("%s.count", tag), 64'(bus.pendingCount), 64'(c));
   endtask

   task automatic check_sweep(input string tag);
      int unsigned c = 0;
      for (int unsigned p = 0; p < NP8; p++) begin
         logic [AW8-1:0] a;
         logic [DW8-1:0] ed;
         logic           ev;
         a  = bus8.ctrl_readReg[p*AW8 +: AW8];
         ed = m8_reg[a];
         ev = !m8_pend[a];
         if (a == 0) begin
            ed = '0;
            ev = 1'b1;
         end
`ifdef REGFILE_BYPASS_EN
         else if (bus8.ctrl_writeEnable && bus8.ctrl_writeReg == a) begin
            ed = bus8.data_writeReg;
            ev = !(bus8.ctrl_issueEnable && bus8.ctrl_issueReg == a);
         end
`endif
         check($sformatf("%s.data%0d", tag, p), 64'(bus8.data_readReg[p*DW8 +: DW8]), 64'(ed));
         check($sformatf("%s.valid%0d", tag, p), 64'(bus8.readValid[p]), 64'(ev));
      end
      for (int unsigned r = 0; r < NR8; r++) if (m8_pend[r]) c++;
      check($sformatf("%s.count", tag), 64'(bus8.pendingCount), 64'(c));
   endtask

   task automatic drive(input bit we, input int unsigned wa, input logic [DW-1:0] wd,
                        input bit ie, input int unsigned ia);
      bus.ctrl_writeEnable = we;
      bus.ctrl_writeReg    = AW'(wa);
      bus.data_writeReg    = wd;
      bus.ctrl_issueEnable = ie;
      bus.ctrl_issueReg    = AW'(ia);
   endtask

   task automatic drive8(input bit we, input int unsigned wa, input logic [DW8-1:0] wd,
                         input bit ie, input int unsigned ia);
      bus8.ctrl_writeEnable = we;
      bus8.ctrl_writeReg    = AW8'(wa);
      bus8.data_writeReg    = wd;
      bus8.ctrl_issueEnable = ie;
      bus8.ctrl_issueReg    = AW8'(ia);
   endtask

   task automatic set_rd(input int unsigned p, input int unsigned a);
      bus.ctrl_readReg[p*AW +: AW] = AW'(a);
   endtask

   task automatic set_rd8(input int unsigned p, input int unsigned a);
      bus8.ctrl_readReg[p*AW8 +: AW8] = AW8'(a);
   endtask

   // one rising edge: update model, idle the inputs, check both instances
   task automatic tick(input string tag);
      @(posedge clock);
      model_edge();
      #1;
      drive(0, 0, '0, 0, 0);
      drive8(0, 0, '0, 0, 0);
      #1;
      check_main(tag);
      check_sweep({tag, "_s"});
   endtask

   initial begin
      ctrl_reset_n      = 1'b0;
      drive(0, 0, '0, 0, 0);
      drive8(0, 0, '0, 0, 0);
      bus.ctrl_readReg  = '0;
      bus8.ctrl_readReg = '0;
      model_reset();

      // reset state
      set_rd(0, 5); set_rd(1, 31);
      #2;
      check_main("reset");
      check_sweep("reset_s");
      #10;
      ctrl_reset_n = 1'b1;

      // write then read; write to r0 ignored
      set_rd(0, 3); set_rd(1, 0);
      drive(1, 3, 32'h12345678, 0, 0);
      #1 check_main("wr3_pre");
      tick("wr3");
      check("wr3.const", 64'(bus.data_readReg[31:0]), 64'h12345678);
      drive(1, 0, 32'hFFFFFFFF, 0, 0);
      #1 check_main("wr0_pre");
      tick("wr0");
      check("wr0.const", 64'(bus.data_readReg[63:32]), 64'h0);

      // scoreboard
      set_rd(0, 4);
      drive(0, 0, '0, 1, 4); tick("iss4");
      check("iss4.valid", 64'(bus.readValid[0]), 64'h0);
      check("iss4.count", 64'(bus.pendingCount), 64'h1);
      drive(0, 0, '0, 1, 4); tick("iss4b");
      check("iss4b.count", 64'(bus.pendingCount), 64'h1);
      drive(1, 4, 32'hA5, 0, 0); tick("wr4");
      check("wr4.count", 64'(bus.pendingCount), 64'h0);

      // simultaneous write+issue: same register, then different registers
      set_rd(0, 9);
      drive(1, 9, 32'h0BADF00D, 1, 9); tick("wi9");
      check("wi9.data", 64'(bus.data_readReg[31:0]), 64'h0BADF00D);
      check("wi9.valid", 64'(bus.readValid[0]), 64'h0);
      check("wi9.count", 64'(bus.pendingCount), 64'h1);
      set_rd(0, 2); set_rd(1, 6);
      drive(1, 6, 32'h66666666, 1, 2); tick("w6i2");
      check("w6i2.count", 64'(bus.pendingCount), 64'h2);

      // bypass window (model follows the build's macro)
      set_rd(1, 10);
      drive(1, 10, 32'hCAFEF00D, 0, 0);
      #1 check_main("byp_pre");
`ifdef REGFILE_BYPASS_EN
      check("byp.const", 64'(bus.data_readReg[63:32]), 64'hCAFEF00D);
`else
      check("byp.const", 64'(bus.data_readReg[63:32]), 64'h0);
`endif
      tick("byp");
      drive(1, 10, 32'h10101010, 1, 10);
      #1 check_main("bypi_pre");
      tick("bypi");

      // reset mid-operation
      set_rd(0, 5); set_rd(1, 7);
      drive(1, 5, 32'hDEADBEEF, 1, 7); tick("pre_rst");
      @(negedge clock);
      ctrl_reset_n = 1'b0;
      #1;
      model_reset();
      check_main("midrst");
      check("midrst.count", 64'(bus.pendingCount), 64'h0);
      @(negedge clock);
      ctrl_reset_n = 1'b1;

      // randomized traffic, addresses biased low to force collisions
      for (int unsigned n = 0; n < 300; n++) begin
         int unsigned wa, ia;
         wa = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, NR-1);
         ia = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, NR-1);
         drive($urandom_range(0, 1), wa, $urandom, $urandom_range(0, 2) == 0, ia);
         set_rd(0, $urandom_range(0, 1) != 0 ? wa : $urandom_range(0, NR-1));
         set_rd(1, $urandom_range(0, 3));
         #1 check_main("rnd_pre");
         tick("rnd");
      end

      // 8x16, 3-port instance: fill, issue all, read distinct registers
      for (int unsigned r = 1; r < NR8; r++) begin
         drive8(1, r, 16'($urandom), 0, 0);
         tick("fill8");
      end
      for (int unsigned r = 1; r < NR8; r++) begin
         drive8(0, 0, '0, 1, r);
         tick("iss8");
      end
      check("iss8.count7", 64'(bus8.pendingCount), 64'h7);
      set_rd8(0, 2); set_rd8(1, 5); set_rd8(2, 7);
      #1 check_sweep("rd8");
      set_rd8(0, 0);
      #1 check_sweep("rd8z");
      check("rd8z.valid0", 64'(bus8.readValid[0]), 64'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
